// File: rtl/absmem_cmp_ctrl.sv
// Single-shot refinement-check sequencer: issues one instruction window per reset,
// waits for ILA commit and implementation completion, pulses compare, latches the verdict.
module absmem_cmp_ctrl #(
   parameter int CW      = 8,
   parameter int MAX_CYC = 20,
   parameter int MIN_CYC = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          ila_commit,
   input  logic          vlg_done,
   input  logic          mem_equal,
   input  logic          state_equal,
   input  logic          read_assume_true,
   output logic          issue,
   output logic          compare,
   output logic          busy,
   output logic          ila_done,
   output logic [CW-1:0] cycle_cnt,
   output logic          done,
   output logic          pass,
   output logic          fail,
   output logic          timeout,
   output logic          assume_ok
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_WAIT    = 3'd2,
      S_COMPARE = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   localparam logic [CW-1:0] C_MIN = CW'(MIN_CYC);
   localparam logic [CW-1:0] C_MAX = CW'(MAX_CYC);

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_ila_done;
   logic          r_done;
   logic          r_pass;
   logic          r_fail;
   logic          r_timeout;
   logic          r_assume_ok;

   logic          w_busy;
   logic          w_track_commit;
   logic          w_cmp_go;

   assign w_busy         = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_COMPARE);
   assign w_track_commit = (r_state == S_ISSUE) || (r_state == S_WAIT);
   // A commit arriving in the same cycle as completion counts, so the live input is ORed in.
   assign w_cmp_go       = vlg_done && (r_ila_done || ila_commit) && (r_cnt >= C_MIN);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_ila_done  <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_fail      <= 1'b0;
         r_timeout   <= 1'b0;
         r_assume_ok <= 1'b1;
      end else begin
         if (w_track_commit && ila_commit)
            r_ila_done <= 1'b1;
         if (w_busy && !read_assume_true)
            r_assume_ok <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (start)
                  r_state <= S_ISSUE;
            end
            S_ISSUE: begin
               r_cnt   <= '0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               // Completion takes priority over the timeout on the last allowed count.
               if (w_cmp_go) begin
                  r_state <= S_COMPARE;
               end else if (r_cnt == C_MAX) begin
                  r_state   <= S_DONE;
                  r_done    <= 1'b1;
                  r_fail    <= 1'b1;
                  r_timeout <= 1'b1;
               end else if (r_cnt != {CW{1'b1}}) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_COMPARE: begin
               r_state <= S_DONE;
               r_done  <= 1'b1;
               r_pass  <= mem_equal && state_equal;
               r_fail  <= !(mem_equal && state_equal);
            end
            S_DONE: begin
               r_state <= S_DONE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign issue     = (r_state == S_ISSUE);
   assign compare   = (r_state == S_COMPARE);
   assign busy      = w_busy;
   assign ila_done  = r_ila_done;
   assign cycle_cnt = r_cnt;
   assign done      = r_done;
   assign pass      = r_pass;
   assign fail      = r_fail;
   assign timeout   = r_timeout;
   assign assume_ok = r_assume_ok;

endmodule
